rib_rr_arbiter: RTL and testbench
=================================

# rib_rr_arbiter

Round-robin, transaction-locking arbiter that shares one RIB master port among `MASTER_NUM` requesters (core instruction fetch, core load/store, JTAG debug, DMA). It sits between the masters and the RIB address decoder/slave mux. It holds a grant from request acceptance through response completion, so a higher-priority master cannot steal the bus mid-transaction. A response timeout keeps a dead slave from locking the bus.

## Interface
- `MASTER_NUM`, 4: number of requesters, 2..8.
- `TIMEOUT`, 255: maximum cycles in RSP before an error response is forced. 0 disables the timeout.

- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `m_req_vld_i` in MASTER_NUM: per-master request valid.
- `m_addr_i` in 32*MASTER_NUM: packed addresses; master k occupies [32k+31:32k].
- `m_data_i` in 32*MASTER_NUM: packed write data.
- `m_sel_i` in 4*MASTER_NUM: packed byte selects.
- `m_we_i` in MASTER_NUM: write enable.
- `m_rsp_rdy_i` in MASTER_NUM: per-master response ready.
- `m_req_rdy_o` out MASTER_NUM: request accepted; only the granted bit can be 1.
- `m_rsp_vld_o` out MASTER_NUM: response valid; only the granted bit can be 1.
- `m_data_o` out 32: read data, shared; qualified by `m_rsp_vld_o`.
- `bus_addr_o`, `bus_data_o` out 32: muxed request to the decoder.
- `bus_sel_o` out 4, `bus_we_o` out 1, `bus_req_vld_o` out 1, `bus_rsp_rdy_o` out 1: muxed request and response-ready to the decoder.
- `bus_req_rdy_i`, `bus_rsp_vld_i` in 1; `bus_data_i` in 32: decoder returns.
- `grant_o` out MASTER_NUM: registered one-hot grant; 0 when IDLE.
- `timeout_o` out 1: one-cycle pulse when a timeout fires.

## Operation
- FSM states: IDLE, REQ, RSP, ERR. The state, `grant_o` and `ptr` are registered.
- Pick rule: the first requesting master scanning `ptr`, `ptr`+1, … modulo MASTER_NUM. `ptr` resets to 0.
- IDLE:
  - If any `m_req_vld_i` is set: register the pick into the grant and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Drive the `bus_*` request fields from the granted master. `bus_req_vld_o` = granted `m_req_vld_i`.
  - Route `bus_req_rdy_i` to the granted `m_req_rdy_o` bit.
  - `bus_rsp_rdy_o` = 0.
  - On handshake (vld & rdy): go to RSP and clear the timeout counter.
  - If the granted master drops vld without a handshake: go to IDLE with no `ptr` update.
- RSP:
  - `bus_req_vld_o` = 0. `bus_rsp_rdy_o` = granted `m_rsp_rdy_i`.
  - `m_rsp_vld_o[g]` = `bus_rsp_vld_i`. `m_data_o` = `bus_data_i`.
  - Counter increments each cycle without a response handshake.
  - On handshake: `ptr` = (g+1) mod MASTER_NUM. If any request is pending, arbitrate with the new `ptr` and go directly to REQ; otherwise go to IDLE.
- Timeout: in RSP, if TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no handshake:
  - Pulse `timeout_o` and go to ERR.
- ERR:
  - `bus_rsp_rdy_o` = 1, which drains any late response.
  - `m_rsp_vld_o[g]` = 1, `m_data_o` = 0.
  - On `m_rsp_rdy_i[g]`: update `ptr` as for RSP, then arbitrate exactly as for an RSP completion.
- Outside the granted path, all `bus_*` request outputs and `m_data_o` are driven to 0.

## Timing
- Reset values: state IDLE, `ptr` 0, all outputs 0.
- `rst` asserted mid-transaction aborts to IDLE at that edge. No response is generated.
- Request-to-grant latency:
  - 1 cycle from IDLE: `m_req_vld_i` at cycle 0 gives `bus_req_vld_o` at cycle 1.
  - 0 extra cycles after an RSP or ERR completion when a request is pending.
- The request/response data paths are combinational within a state. There is no added latency once granted.
- Minimum transaction: 2 cycles (REQ 1 + RSP 1). Back-to-back transactions from different masters run with no idle gap.
- A slave response asserted in the same cycle as the request handshake is not accepted (`bus_rsp_rdy_o` = 0 in REQ). It completes the following cycle if held.
- Simultaneous timeout and handshake in the same cycle: the handshake wins and no `timeout_o` is raised.
- Counter width: $clog2(TIMEOUT+1). It saturates and never wraps.

## Structure
- Shared package `rib_pkg`: state enum (IDLE, REQ, RSP, ERR), `RIB_AW` = 32, `RIB_DW` = 32, `RIB_SW` = 4.
- One sub-module, `rib_rr_pick`: combinational round-robin picker (req vector + `ptr` → one-hot + index).
- Widening MASTER_NUM beyond 8 is not supported.

## Test plan
- Single master 2 requests at cycle 0, `bus_req_rdy_i` = 1, response at cycle 2 with data 0x1234_5678 → `m_req_rdy_o[2]` at cycle 1; `m_rsp_vld_o[2]` with data 0x1234_5678 at cycle 2; `ptr` = 3.
- Masters 0, 1, 3 request continuously; every slave responds in 1 cycle → grants cycle 0→1→3→0 with no idle cycles between transactions.
- Master 1 granted; master 0 raises req during RSP with a 5-cycle response delay → grant stays on 1 until its response handshake, then switches to 0.
- TIMEOUT = 4, slave never responds → `timeout_o` pulses 4 cycles after entering RSP; `m_rsp_vld_o[g]` = 1 with data 0; next pending master is granted after `m_rsp_rdy_i`.
- `rst` asserted while in RSP → next cycle all outputs 0, `grant_o` = 0; a subsequent request from master 2 with master 0 also requesting grants master 0 (`ptr` = 0).

Source files
------------

// File: rtl/rib_pkg.sv
// Shared RIB bus widths and the arbiter state encoding.
package rib_pkg;

  localparam int RIB_AW = 32;
  localparam int RIB_DW = 32;
  localparam int RIB_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    ERR  = 2'd3
  } rib_state_e;

endpackage

// File: rtl/rib_rr_pick.sv
// Combinational round-robin picker: first set request scanning from i_ptr upward, wrapping.
module rib_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic          w_found;
  logic [PW-1:0] w_cand;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return PW'(sum);
  endfunction

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = wrap_idx(i_ptr, i);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/rib_rr_arbiter.sv
// Round-robin RIB arbiter that locks the grant from request acceptance to response
// completion, with an optional response timeout that forces an error response.
module rib_rr_arbiter
  import rib_pkg::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MASTER_NUM-1:0]        m_req_vld_i,
  input  logic [RIB_AW*MASTER_NUM-1:0] m_addr_i,
  input  logic [RIB_DW*MASTER_NUM-1:0] m_data_i,
  input  logic [RIB_SW*MASTER_NUM-1:0] m_sel_i,
  input  logic [MASTER_NUM-1:0]        m_we_i,
  input  logic [MASTER_NUM-1:0]        m_rsp_rdy_i,
  output logic [MASTER_NUM-1:0]        m_req_rdy_o,
  output logic [MASTER_NUM-1:0]        m_rsp_vld_o,
  output logic [RIB_DW-1:0]            m_data_o,
  output logic [RIB_AW-1:0]            bus_addr_o,
  output logic [RIB_DW-1:0]            bus_data_o,
  output logic [RIB_SW-1:0]            bus_sel_o,
  output logic                         bus_we_o,
  output logic                         bus_req_vld_o,
  output logic                         bus_rsp_rdy_o,
  input  logic                         bus_req_rdy_i,
  input  logic                         bus_rsp_vld_i,
  input  logic [RIB_DW-1:0]            bus_data_i,
  output logic [MASTER_NUM-1:0]        grant_o,
  output logic                         timeout_o
);

  localparam int              PW       = $clog2(MASTER_NUM);
  localparam int              CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [PW-1:0]   IDX_LAST = PW'(MASTER_NUM - 1);

  rib_state_e            r_state;
  logic [MASTER_NUM-1:0] r_grant;
  logic [PW-1:0]         r_gidx;
  logic [PW-1:0]         r_ptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_timeout;

  logic [RIB_AW-1:0] w_addr [MASTER_NUM];
  logic [RIB_DW-1:0] w_wdata [MASTER_NUM];
  logic [RIB_SW-1:0] w_sel [MASTER_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < MASTER_NUM; gi++) begin : g_unpack
      assign w_addr[gi]  = m_addr_i[gi*RIB_AW +: RIB_AW];
      assign w_wdata[gi] = m_data_i[gi*RIB_DW +: RIB_DW];
      assign w_sel[gi]   = m_sel_i[gi*RIB_SW +: RIB_SW];
    end
  endgenerate

  logic [MASTER_NUM-1:0] w_idle_grant, w_next_grant;
  logic [PW-1:0]         w_idle_idx, w_next_idx, w_ptr_next;
  logic                  w_idle_any, w_next_any;
  logic                  w_g_req_vld, w_g_rsp_rdy;
  logic                  w_req_hs, w_rsp_hs, w_err_done, w_done;

  assign w_ptr_next = (r_gidx == IDX_LAST) ? '0 : r_gidx + 1'b1;

  // Two pickers: one for IDLE with the stored pointer, one for completion with
  // the pointer already advanced past the finishing master (zero-gap handover).
  rib_rr_pick #(.N(MASTER_NUM)) u_pick_idle (
    .i_req   (m_req_vld_i),
    .i_ptr   (r_ptr),
    .o_grant (w_idle_grant),
    .o_idx   (w_idle_idx),
    .o_any   (w_idle_any)
  );

  rib_rr_pick #(.N(MASTER_NUM)) u_pick_next (
    .i_req   (m_req_vld_i),
    .i_ptr   (w_ptr_next),
    .o_grant (w_next_grant),
    .o_idx   (w_next_idx),
    .o_any   (w_next_any)
  );

  assign w_g_req_vld = m_req_vld_i[r_gidx];
  assign w_g_rsp_rdy = m_rsp_rdy_i[r_gidx];
  assign w_req_hs    = (r_state == REQ) && w_g_req_vld && bus_req_rdy_i;
  assign w_rsp_hs    = (r_state == RSP) && bus_rsp_vld_i && w_g_rsp_rdy;
  assign w_err_done  = (r_state == ERR) && w_g_rsp_rdy;
  assign w_done      = w_rsp_hs || w_err_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_idle_any) begin
            r_state <= REQ;
            r_grant <= w_idle_grant;
            r_gidx  <= w_idle_idx;
          end
        end
        REQ: begin
          if (w_req_hs) begin
            r_state <= RSP;
            r_cnt   <= '0;
          end else if (!w_g_req_vld) begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        RSP, ERR: begin
          if (w_done) begin
            r_ptr <= w_ptr_next;
            if (w_next_any) begin
              r_state <= REQ;
              r_grant <= w_next_grant;
              r_gidx  <= w_next_idx;
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
            end
          end else if (r_state == RSP) begin
            if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
              r_state   <= ERR;
              r_timeout <= 1'b1;
            end else if (r_cnt != '1) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_req_rdy_o   = '0;
    m_rsp_vld_o   = '0;
    m_data_o      = '0;
    bus_addr_o    = '0;
    bus_data_o    = '0;
    bus_sel_o     = '0;
    bus_we_o      = 1'b0;
    bus_req_vld_o = 1'b0;
    bus_rsp_rdy_o = 1'b0;
    unique case (r_state)
      REQ: begin
        bus_addr_o    = w_addr[r_gidx];
        bus_data_o    = w_wdata[r_gidx];
        bus_sel_o     = w_sel[r_gidx];
        bus_we_o      = m_we_i[r_gidx];
        bus_req_vld_o = w_g_req_vld;
        m_req_rdy_o   = r_grant & {MASTER_NUM{bus_req_rdy_i}};
      end
      RSP: begin
        bus_rsp_rdy_o = w_g_rsp_rdy;
        m_rsp_vld_o   = r_grant & {MASTER_NUM{bus_rsp_vld_i}};
        m_data_o      = bus_data_i;
      end
      ERR: begin
        bus_rsp_rdy_o = 1'b1;
        m_rsp_vld_o   = r_grant;
      end
      default: ;
    endcase
  end

  assign grant_o   = r_grant;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Directed bench for rib_rr_arbiter: one default-timeout instance and one with TIMEOUT=4.
module tb_rib_rr_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld, we, rsp_rdy;
  logic [32*N-1:0] addr, wdata;
  logic [4*N-1:0] sel;
  logic           bus_req_rdy, bus_rsp_vld;
  logic [31:0]    bus_rdata;

  logic [N-1:0] a_req_rdy, a_rsp_vld, a_grant;
  logic [31:0]  a_mdata, a_baddr, a_bdata;
  logic [3:0]   a_bsel;
  logic         a_bwe, a_breq_vld, a_brsp_rdy, a_timeout;

  logic [N-1:0] t_req_rdy, t_rsp_vld, t_grant;
  logic [31:0]  t_mdata, t_baddr, t_bdata;
  logic [3:0]   t_bsel;
  logic         t_bwe, t_breq_vld, t_brsp_rdy, t_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rib_rr_arbiter #(.MASTER_NUM(N), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst),
    .m_req_vld_i(req_vld), .m_addr_i(addr), .m_data_i(wdata), .m_sel_i(sel),
    .m_we_i(we), .m_rsp_rdy_i(rsp_rdy),
    .m_req_rdy_o(a_req_rdy), .m_rsp_vld_o(a_rsp_vld), .m_data_o(a_mdata),
    .bus_addr_o(a_baddr), .bus_data_o(a_bdata), .bus_sel_o(a_bsel), .bus_we_o(a_bwe),
    .bus_req_vld_o(a_breq_vld), .bus_rsp_rdy_o(a_brsp_rdy),
    .bus_req_rdy_i(bus_req_rdy), .bus_rsp_vld_i(bus_rsp_vld), .bus_data_i(bus_rdata),
    .grant_o(a_grant), .timeout_o(a_timeout)
  );

  rib_rr_arbiter #(.MASTER_NUM(N), .TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst),
    .m_req_vld_i(req_vld), .m_addr_i(addr), .m_data_i(wdata), .m_sel_i(sel),
    .m_we_i(we), .m_rsp_rdy_i(rsp_rdy),
    .m_req_rdy_o(t_req_rdy), .m_rsp_vld_o(t_rsp_vld), .m_data_o(t_mdata),
    .bus_addr_o(t_baddr), .bus_data_o(t_bdata), .bus_sel_o(t_bsel), .bus_we_o(t_bwe),
    .bus_req_vld_o(t_breq_vld), .bus_rsp_rdy_o(t_brsp_rdy),
    .bus_req_rdy_i(bus_req_rdy), .bus_rsp_vld_i(bus_rsp_vld), .bus_data_i(bus_rdata),
    .grant_o(t_grant), .timeout_o(t_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst         = 1'b1;
    req_vld     = '0;
    rsp_rdy     = '0;
    bus_req_rdy = 1'b0;
    bus_rsp_vld = 1'b0;
    bus_rdata   = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_g [7];

    for (int k = 0; k < N; k++) begin
      addr[32*k +: 32]  = 32'hA000_0000 | (k << 4);
      wdata[32*k +: 32] = 32'hD000_0000 | k;
    end
    sel = 16'h8421;
    we  = 4'b0101;

    // Reset state with hostile inputs present.
    rst = 1'b1; req_vld = 4'hF; rsp_rdy = 4'hF;
    bus_req_rdy = 1'b1; bus_rsp_vld = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    check("rst_grant", a_grant, 0);
    check("rst_rsp_vld", a_rsp_vld, 0);
    check("rst_mdata", a_mdata, 0);
    check("rst_breq_vld", a_breq_vld, 0);
    check("rst_timeout", t_timeout, 0);

    // Single master 2 transaction.
    rst_pulse();
    req_vld = 4'b0100; bus_req_rdy = 1'b1; rsp_rdy = 4'hF; #1;
    check("t1_idle_grant", a_grant, 0);
    check("t1_idle_req_rdy", a_req_rdy, 0);
    tick();
    check("t1_req_grant", a_grant, 4'b0100);
    check("t1_req_vld", a_breq_vld, 1);
    check("t1_req_addr", a_baddr, 32'hA000_0020);
    check("t1_req_data", a_bdata, 32'hD000_0002);
    check("t1_req_sel", a_bsel, 4'h4);
    check("t1_req_we", a_bwe, 1);
    check("t1_req_rdy", a_req_rdy, 4'b0100);
    check("t1_req_rsp_rdy", a_brsp_rdy, 0);
    tick();
    req_vld = '0; bus_rsp_vld = 1'b1; bus_rdata = 32'h1234_5678; #1;
    check("t1_rsp_vld", a_rsp_vld, 4'b0100);
    check("t1_rsp_data", a_mdata, 32'h1234_5678);
    check("t1_rsp_rdy", a_brsp_rdy, 1);
    check("t1_rsp_req_vld", a_breq_vld, 0);
    check("t1_rsp_addr", a_baddr, 0);
    tick();
    bus_rsp_vld = 1'b0; req_vld = 4'b1001; #1;
    check("t1_done_grant", a_grant, 0);
    $display("[TB] txn master2 read data 0x%0h", 32'h1234_5678);
    tick();
    check("t1_ptr3_grant", a_grant, 4'b1000);
    tick();
    req_vld = 4'b0001; bus_rsp_vld = 1'b1; #1;
    check("t1_m3_rsp_vld", a_rsp_vld, 4'b1000);
    tick();
    bus_rsp_vld = 1'b0; #1;
    check("t1_wrap_grant", a_grant, 4'b0001);
    check("t1_wrap_req_vld", a_breq_vld, 1);
    $display("[TB] txn master3 then master0 handover");

    // Continuous requests from masters 0, 1, 3 with single-cycle slaves.
    rst_pulse();
    req_vld = 4'b1011; bus_req_rdy = 1'b1; bus_rsp_vld = 1'b1; rsp_rdy = 4'hF;
    bus_rdata = 32'h5555_0000; #1;
    check("t2_c0_grant", a_grant, 0);
    exp_g = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0001};
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("t2_c%0d_grant", i + 1), a_grant, exp_g[i]);
      check($sformatf("t2_c%0d_req_vld", i + 1), a_breq_vld, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t2_c%0d_rsp_vld", i + 1), a_rsp_vld, (i % 2 == 1) ? exp_g[i] : 4'b0000);
      if (i % 2 == 1) $display("[TB] txn grant 0x%0h completed", exp_g[i]);
    end

    // Grant locking: master 0 arrives while master 1 waits for a slow response.
    rst_pulse();
    req_vld = 4'b0010; bus_req_rdy = 1'b1; rsp_rdy = 4'hF;
    tick();
    check("t3_req_grant", a_grant, 4'b0010);
    tick();
    req_vld = 4'b0001; #1;
    check("t3_rsp0_grant", a_grant, 4'b0010);
    check("t3_rsp0_vld", a_rsp_vld, 0);
    tick();
    check("t3_rsp1_grant", a_grant, 4'b0010);
    tick();
    rsp_rdy = 4'b1101; #1;
    check("t3_rsp2_grant", a_grant, 4'b0010);
    check("t3_rsp2_rsp_rdy", a_brsp_rdy, 0);
    tick();
    rsp_rdy = 4'hF; #1;
    check("t3_rsp3_grant", a_grant, 4'b0010);
    tick();
    bus_rsp_vld = 1'b1; bus_rdata = 32'h0BAD_F00D; #1;
    check("t3_rsp4_vld", a_rsp_vld, 4'b0010);
    check("t3_rsp4_data", a_mdata, 32'h0BAD_F00D);
    tick();
    bus_rsp_vld = 1'b0; #1;
    check("t3_switch_grant", a_grant, 4'b0001);
    check("t3_switch_addr", a_baddr, 32'hA000_0000);
    $display("[TB] txn master1 slow response then master0");

    // Timeout on the TIMEOUT=4 instance, then handover to master 3.
    rst_pulse();
    req_vld = 4'b0010; bus_req_rdy = 1'b1; rsp_rdy = 4'b0000;
    tick();
    check("t4_req_grant", t_grant, 4'b0010);
    tick();
    req_vld = 4'b1000; bus_rdata = 32'hFFFF_FFFF; #1;
    check("t4_rsp0_timeout", t_timeout, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("t4_rsp%0d_timeout", i), t_timeout, 0);
      check($sformatf("t4_rsp%0d_vld", i), t_rsp_vld, 0);
    end
    tick();
    check("t4_err_timeout", t_timeout, 1);
    check("t4_err_rsp_vld", t_rsp_vld, 4'b0010);
    check("t4_err_data", t_mdata, 0);
    check("t4_err_rsp_rdy", t_brsp_rdy, 1);
    tick();
    rsp_rdy = 4'b0010; #1;
    check("t4_err2_timeout", t_timeout, 0);
    check("t4_err2_rsp_vld", t_rsp_vld, 4'b0010);
    tick();
    check("t4_next_grant", t_grant, 4'b1000);
    check("t4_next_req_vld", t_breq_vld, 1);
    $display("[TB] txn master1 timed out, master3 granted");

    // Response on the last allowed cycle beats the timeout.
    tick();
    req_vld = '0; rsp_rdy = 4'hF;
    tick();
    tick();
    tick();
    bus_rsp_vld = 1'b1; bus_rdata = 32'h0000_00A5; #1;
    check("t4b_last_rsp_vld", t_rsp_vld, 4'b1000);
    tick();
    bus_rsp_vld = 1'b0; #1;
    check("t4b_no_timeout", t_timeout, 0);
    check("t4b_idle_grant", t_grant, 0);
    $display("[TB] txn master3 response at timeout boundary");

    // Reset in RSP clears the pointer as well as the transaction.
    rst_pulse();
    req_vld = 4'b0010; bus_req_rdy = 1'b1; rsp_rdy = 4'hF;
    tick();
    tick();
    req_vld = '0; bus_rsp_vld = 1'b1;
    tick();
    bus_rsp_vld = 1'b0; req_vld = 4'b0100;
    tick();
    check("t5_m2_grant", a_grant, 4'b0100);
    tick();
    req_vld = '0; rst = 1'b1; #1;
    check("t5_rsp_grant", a_grant, 4'b0100);
    tick();
    rst = 1'b0; req_vld = 4'b0101; bus_rsp_vld = 1'b1; bus_rdata = 32'h7777_7777; #1;
    check("t5_post_grant", a_grant, 0);
    check("t5_post_rsp_vld", a_rsp_vld, 0);
    check("t5_post_data", a_mdata, 0);
    check("t5_post_req_vld", a_breq_vld, 0);
    check("t5_post_req_rdy", a_req_rdy, 0);
    tick();
    check("t5_ptr0_grant", a_grant, 4'b0001);
    $display("[TB] txn reset mid-response, master0 granted");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
